// File: rtl/uart_pkg.sv
// Shared definitions for the UART: receiver state numbering, synchronizer depth
// and the parity helper used by both directions.
package uart_pkg;

    // Receiver states for the default 8-bit frame. Data states run consecutively
    // from DATA_BIT_0, so other widths shift PARITY_BIT/STOP_BIT accordingly.
    localparam int IDLE       = 0;
    localparam int START_BIT  = 1;
    localparam int DATA_BIT_0 = 2;
    localparam int DATA_BIT_1 = 3;
    localparam int DATA_BIT_2 = 4;
    localparam int DATA_BIT_3 = 5;
    localparam int DATA_BIT_4 = 6;
    localparam int DATA_BIT_5 = 7;
    localparam int DATA_BIT_6 = 8;
    localparam int DATA_BIT_7 = 9;
    localparam int PARITY_BIT = 10;
    localparam int STOP_BIT   = 11;

    // Flops between the asynchronous serial_in pin and the receiver logic.
    localparam int NUMBER_OF_RX_SYNCHRONIZERS = 3;

    // Parity bit for a payload: even parity when odd=0, odd parity when odd=1.
    // Callers zero-extend the payload, which leaves its XOR reduction unchanged.
    function automatic logic calc_parity(input logic [63:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// UART receiver: synchronizes the serial line, detects the start edge, samples
// each bit mid-period and checks parity and the stop bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int INPUT_DATA_WIDTH = 8,
    parameter int PARITY_ENABLED   = 1,
    parameter int PARITY_TYPE      = 0,
    parameter int CLOCKS_PER_BIT   = 8,
    parameter int STATE_WIDTH      = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        serial_in,
    output logic [INPUT_DATA_WIDTH-1:0] received_data,
    output logic                        data_is_valid,
    output logic                        rx_error,
    output logic [STATE_WIDTH-1:0]      state,
    output logic                        serial_in_synced,
    output logic                        start_detected,
    output logic                        sampling_strobe
);

    localparam int SW = STATE_WIDTH;
    localparam int NS = NUMBER_OF_RX_SYNCHRONIZERS;
    localparam int CW = $clog2(CLOCKS_PER_BIT);
    localparam logic ODD = (PARITY_TYPE != 0);

    localparam logic [SW-1:0] S_IDLE   = SW'(IDLE);
    localparam logic [SW-1:0] S_START  = SW'(START_BIT);
    localparam logic [SW-1:0] S_D0     = SW'(DATA_BIT_0);
    localparam logic [SW-1:0] S_DLAST  = SW'(DATA_BIT_0 + INPUT_DATA_WIDTH - 1);
    localparam logic [SW-1:0] S_PARITY = SW'(DATA_BIT_0 + INPUT_DATA_WIDTH);
    localparam logic [SW-1:0] S_STOP   = SW'(DATA_BIT_0 + INPUT_DATA_WIDTH + 1);

    logic [NS-1:0]               sync_ff;
    logic                        synced_prev;
    logic [CW-1:0]               bit_cnt;
    logic [SW-1:0]               state_nxt;
    logic [INPUT_DATA_WIDTH-1:0] data_nxt;
    logic                        valid_nxt;
    logic                        error_nxt;

    assign serial_in_synced = sync_ff[NS-1];
    assign start_detected   = (state == S_IDLE) && !serial_in_synced && synced_prev;
    assign sampling_strobe  = (state != S_IDLE) && (bit_cnt == CW'(CLOCKS_PER_BIT/2 - 1));

    // Synchronizer chain plus one extra flop of history for falling-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_ff     <= '1;
            synced_prev <= 1'b1;
        end else begin
            sync_ff     <= {sync_ff[NS-2:0], serial_in};
            synced_prev <= serial_in_synced;
        end
    end

    // Bit-period counter, realigned to the start edge so the strobe lands mid-bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt <= '0;
        end else if (start_detected || bit_cnt == CW'(CLOCKS_PER_BIT - 1)) begin
            bit_cnt <= '0;
        end else begin
            bit_cnt <= bit_cnt + CW'(1);
        end
    end

    // Receiver state, payload and result pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            received_data <= '0;
            data_is_valid <= 1'b0;
            rx_error      <= 1'b0;
        end else begin
            state         <= state_nxt;
            received_data <= data_nxt;
            data_is_valid <= valid_nxt;
            rx_error      <= error_nxt;
        end
    end

    // Next-state and payload decode; pulses default low every cycle.
    always_comb begin
        state_nxt = state;
        data_nxt  = received_data;
        valid_nxt = 1'b0;
        error_nxt = 1'b0;
        if (state == S_IDLE) begin
            if (start_detected) begin
                state_nxt = S_START;
            end
        end else if (state == S_START) begin
            if (sampling_strobe) begin
                if (serial_in_synced) begin
                    state_nxt = S_IDLE;
                end else begin
                    data_nxt  = '0;
                    state_nxt = S_D0;
                end
            end
        end else if (state >= S_D0 && state <= S_DLAST) begin
            if (sampling_strobe) begin
                data_nxt = {serial_in_synced, received_data[INPUT_DATA_WIDTH-1:1]};
                if (state != S_DLAST) begin
                    state_nxt = state + SW'(1);
                end else if (PARITY_ENABLED != 0) begin
                    state_nxt = S_PARITY;
                end else begin
                    state_nxt = S_STOP;
                end
            end
        end else if (state == S_PARITY && PARITY_ENABLED != 0) begin
            if (sampling_strobe) begin
                if (serial_in_synced == calc_parity(64'(received_data), ODD)) begin
                    valid_nxt = 1'b1;
                end else begin
                    error_nxt = 1'b1;
                end
                state_nxt = S_STOP;
            end
        end else if (state == S_STOP) begin
            if (sampling_strobe) begin
                if (!serial_in_synced) begin
                    error_nxt = 1'b1;
                end else if (PARITY_ENABLED == 0) begin
                    valid_nxt = 1'b1;
                end
                data_nxt  = '0;
                state_nxt = S_IDLE;
            end
        end else begin
            state_nxt = S_IDLE;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: loads a framed word into a PISO on accept and shifts it out
// LSB first, one bit per baud strobe. Idle is shift_reg all ones.
module uart_tx
    import uart_pkg::*;
#(
    parameter int INPUT_DATA_WIDTH = 8,
    parameter int PARITY_ENABLED   = 1,
    parameter int PARITY_TYPE      = 0,
    parameter int NUMBER_OF_BITS   = INPUT_DATA_WIDTH + PARITY_ENABLED + 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        baud_clk,
    input  logic                        enable,
    input  logic [INPUT_DATA_WIDTH-1:0] i_data,
    output logic                        o_busy,
    output logic                        serial_out,
    output logic [NUMBER_OF_BITS-1:0]   shift_reg
);

    localparam logic ODD = (PARITY_TYPE != 0);

    logic [NUMBER_OF_BITS-1:0] frame;

    // Frame layout, LSB first on the wire: start(0), data, optional parity, stop(1).
    always_comb begin
        frame                      = '1;
        frame[0]                   = 1'b0;
        frame[INPUT_DATA_WIDTH:1]  = i_data;
        if (PARITY_ENABLED != 0) begin
            frame[INPUT_DATA_WIDTH+1] = calc_parity(64'(i_data), ODD);
        end
    end

    // Any value other than all-ones is a pending frame; the zero value left after
    // the stop bit keeps busy asserted for the whole stop-bit period.
    assign o_busy = (shift_reg != '1);

    // Accept when idle; otherwise shift on each baud strobe and return to idle
    // one bit time after the stop bit was driven.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_reg  <= '1;
            serial_out <= 1'b1;
        end else if (!o_busy) begin
            if (enable) begin
                shift_reg <= frame;
            end
        end else if (baud_clk) begin
            if (shift_reg == '0) begin
                shift_reg <= '1;
            end else begin
                serial_out <= shift_reg[0];
                shift_reg  <= shift_reg >> 1;
            end
        end
    end

endmodule

// File: rtl/uart.sv
// Full-duplex UART top: shared free-running baud generator driving the
// transmitter, plus an independent oversampling receiver.
module uart
    import uart_pkg::*;
#(
    parameter int INPUT_DATA_WIDTH = 8,
    parameter int PARITY_ENABLED   = 1,
    parameter int PARITY_TYPE      = 0,
    parameter int CLOCKS_PER_BIT   = 8,
    localparam int NUMBER_OF_BITS  = INPUT_DATA_WIDTH + PARITY_ENABLED + 2,
    localparam int STATE_WIDTH     = $clog2(NUMBER_OF_BITS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [INPUT_DATA_WIDTH-1:0] i_data,
    output logic                        o_busy,
    output logic                        serial_out,
    input  logic                        serial_in,
    output logic [INPUT_DATA_WIDTH-1:0] received_data,
    output logic                        data_is_valid,
    output logic                        rx_error,
    output logic                        baud_clk,
    output logic [NUMBER_OF_BITS-1:0]   shift_reg,
    output logic [STATE_WIDTH-1:0]      state,
    output logic                        serial_in_synced,
    output logic                        start_detected,
    output logic                        sampling_strobe
);

    localparam int BW = $clog2(CLOCKS_PER_BIT);

    logic [BW-1:0] baud_cnt;

    assign baud_clk = (baud_cnt == BW'(CLOCKS_PER_BIT - 1));

    // Free-running baud divider, wrapping at CLOCKS_PER_BIT-1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            baud_cnt <= '0;
        end else if (baud_clk) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + BW'(1);
        end
    end

    uart_tx #(
        .INPUT_DATA_WIDTH (INPUT_DATA_WIDTH),
        .PARITY_ENABLED   (PARITY_ENABLED),
        .PARITY_TYPE      (PARITY_TYPE),
        .NUMBER_OF_BITS   (NUMBER_OF_BITS)
    ) u_tx (
        .clk        (clk),
        .reset      (reset),
        .baud_clk   (baud_clk),
        .enable     (enable),
        .i_data     (i_data),
        .o_busy     (o_busy),
        .serial_out (serial_out),
        .shift_reg  (shift_reg)
    );

    uart_rx #(
        .INPUT_DATA_WIDTH (INPUT_DATA_WIDTH),
        .PARITY_ENABLED   (PARITY_ENABLED),
        .PARITY_TYPE      (PARITY_TYPE),
        .CLOCKS_PER_BIT   (CLOCKS_PER_BIT),
        .STATE_WIDTH      (STATE_WIDTH)
    ) u_rx (
        .clk              (clk),
        .reset            (reset),
        .serial_in        (serial_in),
        .received_data    (received_data),
        .data_is_valid    (data_is_valid),
        .rx_error         (rx_error),
        .state            (state),
        .serial_in_synced (serial_in_synced),
        .start_detected   (start_detected),
        .sampling_strobe  (sampling_strobe)
    );

endmodule

// File: tb/tb_uart.sv
// Testbench for uart: an even-parity instance (loopback or externally driven
// Rx line) and an odd-parity instance in loopback.
module tb_uart;

    localparam int CPB = 8;

    // Clock and reset
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // Stimulus
    logic       enable0  = 1'b0;
    logic       enable1  = 1'b0;
    logic [7:0] i_data   = '0;
    logic       ext_mode = 1'b0;
    logic       ext_line = 1'b1;

    // DUT0 (even parity)
    logic        busy0, so0, si0, dv0, err0, baud0, sync0, sd0, ss0;
    logic [7:0]  rxd0;
    logic [10:0] sr0;
    logic [3:0]  st0;
    // DUT1 (odd parity)
    logic        busy1, so1, dv1, err1, baud1, sync1, sd1, ss1;
    logic [7:0]  rxd1;
    logic [10:0] sr1;
    logic [3:0]  st1;

    assign si0 = ext_mode ? ext_line : so0;

    uart dut0 (
        .clk(clk), .reset(reset), .enable(enable0), .i_data(i_data),
        .o_busy(busy0), .serial_out(so0), .serial_in(si0),
        .received_data(rxd0), .data_is_valid(dv0), .rx_error(err0),
        .baud_clk(baud0), .shift_reg(sr0), .state(st0),
        .serial_in_synced(sync0), .start_detected(sd0), .sampling_strobe(ss0)
    );

    uart #(.PARITY_TYPE(1)) dut1 (
        .clk(clk), .reset(reset), .enable(enable1), .i_data(i_data),
        .o_busy(busy1), .serial_out(so1), .serial_in(so1),
        .received_data(rxd1), .data_is_valid(dv1), .rx_error(err1),
        .baud_clk(baud1), .shift_reg(sr1), .state(st1),
        .serial_in_synced(sync1), .start_detected(sd1), .sampling_strobe(ss1)
    );

    // Selected-instance views for the Tx tasks
    int          cur_sel = 0;
    logic        busy_s, so_s;
    logic [10:0] sr_s;
    assign busy_s = (cur_sel == 1) ? busy1 : busy0;
    assign so_s   = (cur_sel == 1) ? so1   : so0;
    assign sr_s   = (cur_sel == 1) ? sr1   : sr0;

    // Scoreboard counters
    int n_checks = 0;
    int n_pass   = 0;

    // Rx pulse monitor
    int         dv_cnt0 = 0, err_cnt0 = 0, sd_cnt0 = 0, dv_cnt1 = 0, err_cnt1 = 0;
    logic [7:0] last_rx0 = '0, last_rx1 = '0;
    always @(negedge clk) begin
        if (dv0)  begin dv_cnt0 <= dv_cnt0 + 1; last_rx0 <= rxd0; end
        if (err0) err_cnt0 <= err_cnt0 + 1;
        if (sd0)  sd_cnt0 <= sd_cnt0 + 1;
        if (dv1)  begin dv_cnt1 <= dv_cnt1 + 1; last_rx1 <= rxd1; end
        if (err1) err_cnt1 <= err_cnt1 + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: parity and on-wire bit list from the framing rules
    function automatic logic exp_parity(input logic [7:0] d, input int odd);
        return ((($countones(d) + odd) % 2) == 1);
    endfunction

    function automatic logic [10:0] exp_frame(input logic [7:0] d, input int odd);
        logic        bits[$];
        logic [10:0] v;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        bits.push_back(exp_parity(d, odd));
        bits.push_back(1'b1);
        for (int i = 0; i < 11; i++) v[i] = bits[i];
        return v;
    endfunction

    // Send one byte on instance sel, check wire bits, busy and the looped-back Rx
    task automatic send_frame(input int sel, input logic [7:0] d, input bit hold);
        int          t;
        int          dv_b, err_b;
        logic [10:0] fr;
        cur_sel = sel;
        fr      = exp_frame(d, sel);
        dv_b    = (sel == 1) ? dv_cnt1 : dv_cnt0;
        err_b   = (sel == 1) ? err_cnt1 : err_cnt0;
        t = 0;
        while (busy_s !== 1'b0 && t < 300) begin tick(1); t++; end
        chk("tx_ready", busy_s, 0);
        i_data = d;
        if (sel == 1) enable1 = 1'b1; else enable0 = 1'b1;
        tick(1);
        chk("busy_after_accept", busy_s, 1);
        chk("shift_reg_load", sr_s, fr);
        if (hold) i_data = ~d;
        else begin enable0 = 1'b0; enable1 = 1'b0; end
        t = 0;
        while (so_s !== 1'b0 && t < CPB + 2) begin tick(1); t++; end
        chk("start_edge", so_s, 0);
        tick(CPB / 2);
        for (int k = 0; k < 11; k++) begin
            chk($sformatf("tx_bit%0d", k), so_s, fr[k]);
            if (k == 10) begin
                chk("busy_in_stop", busy_s, 1);
                enable0 = 1'b0;
                enable1 = 1'b0;
            end
            tick(CPB);
        end
        chk("busy_after_stop", busy_s, 0);
        chk("shift_reg_idle", sr_s, 11'h7FF);
        tick(2 * CPB);
        chk("rx_valid_count", ((sel == 1) ? dv_cnt1 : dv_cnt0) - dv_b, 1);
        chk("rx_error_count", ((sel == 1) ? err_cnt1 : err_cnt0) - err_b, 0);
        chk("rx_data", (sel == 1) ? last_rx1 : last_rx0, d);
        chk("rx_state_idle", (sel == 1) ? st1 : st0, 0);
        chk("rx_data_cleared", (sel == 1) ? rxd1 : rxd0, 0);
    endtask

    // Drive a frame into instance 0's Rx pin and check its verdict
    task automatic drive_rx(input logic [7:0] d, input logic par, input logic stp);
        int   dv_b, err_b;
        logic good;
        dv_b     = dv_cnt0;
        err_b    = err_cnt0;
        good     = (par == exp_parity(d, 0));
        ext_mode = 1'b1;
        ext_line = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin ext_line = d[i]; tick(CPB); end
        ext_line = par;
        tick(CPB);
        ext_line = stp;
        tick(CPB);
        ext_line = 1'b1;
        tick(3 * CPB);
        chk("ext_valid_count", dv_cnt0 - dv_b, good ? 1 : 0);
        chk("ext_error_count", err_cnt0 - err_b, (good ? 0 : 1) + (stp ? 0 : 1));
        if (good) chk("ext_data", last_rx0, d);
        chk("ext_state_idle", st0, 0);
    endtask

    // Watchdog
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int         t;
        int         sd_b, dv_b, err_b;
        logic [7:0] d;

        // Reset state
        tick(3);
        chk("rst_serial_out", so0, 1);
        chk("rst_busy", busy0, 0);
        chk("rst_shift_reg", sr0, 11'h7FF);
        chk("rst_state", st0, 0);
        chk("rst_valid", dv0, 0);
        chk("rst_error", err0, 0);
        chk("rst_rx_data", rxd0, 0);
        reset = 1'b1;
        tick(2 * CPB);
        chk("idle_serial_out", so0, 1);
        chk("idle_busy", busy0, 0);

        // Directed loopback, even parity
        send_frame(0, 8'hA5, 1'b0);
        // Odd-parity instance, 0x01 gives parity bit 0
        send_frame(1, 8'h01, 1'b0);
        // Enable held through the frame with i_data changing
        send_frame(0, 8'h3C, 1'b1);

        // Randomized loopback on both instances
        for (int n = 0; n < 4; n++) send_frame(0, 8'($urandom_range(0, 255)), 1'b0);
        for (int n = 0; n < 2; n++) send_frame(1, 8'($urandom_range(0, 255)), 1'b0);

        // Externally driven Rx: wrong parity, then random parity/stop cases
        tick(2);
        drive_rx(8'hFF, 1'b1, 1'b1);
        for (int n = 0; n < 4; n++) begin
            d = 8'($urandom_range(0, 255));
            drive_rx(d, exp_parity(d, 0) ^ 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Short glitch: start detected, rejected as a false start
        sd_b  = sd_cnt0;
        dv_b  = dv_cnt0;
        err_b = err_cnt0;
        ext_line = 1'b0;
        tick(2);
        ext_line = 1'b1;
        tick(2 * CPB);
        chk("glitch_start_seen", sd_cnt0 - sd_b, 1);
        chk("glitch_state_idle", st0, 0);
        chk("glitch_no_valid", dv_cnt0 - dv_b, 0);
        chk("glitch_no_error", err_cnt0 - err_b, 0);
        ext_mode = 1'b0;
        tick(2);

        // Async reset in the middle of a loopback frame
        cur_sel = 0;
        i_data  = 8'($urandom_range(0, 255));
        enable0 = 1'b1;
        tick(1);
        enable0 = 1'b0;
        t = 0;
        while (st0 !== 4'd5 && t < 300) begin tick(1); t++; end
        chk("reach_data_bit_3", st0, 5);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_state", st0, 0);
        chk("mid_rst_serial_out", so0, 1);
        chk("mid_rst_busy", busy0, 0);
        chk("mid_rst_shift_reg", sr0, 11'h7FF);
        chk("mid_rst_rx_data", rxd0, 0);
        chk("mid_rst_valid", dv0, 0);
        @(negedge clk);
        reset = 1'b1;
        tick(2);
        send_frame(0, 8'($urandom_range(0, 255)), 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
